// File: rtl/branch_flag_resolver.sv
// Execute-stage branch resolver: turns SUB flags into a branch outcome, redirects
// fetch on a mispredict and trains a direct-mapped table of 2-bit counters.
module branch_flag_resolver #(
  parameter int BIT_COUNT      = 32,
  parameter int BHT_INDEX_BITS = 4,
  parameter int COUNT_BITS     = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [BIT_COUNT-1:0]  FetchPC,
  output logic                  PredictTaken,
  input  logic                  ResolveValid,
  input  logic [2:0]            ResolveFunct3,
  input  logic [BIT_COUNT-1:0]  ResolvePC,
  input  logic [BIT_COUNT-1:0]  ResolveTarget,
  input  logic                  ResolvePredictedTaken,
  input  logic                  Zero,
  input  logic                  oVerflow,
  input  logic                  Negative,
  input  logic                  Carry,
  output logic                  Redirect,
  output logic [BIT_COUNT-1:0]  RedirectPC,
  output logic [COUNT_BITS-1:0] MispredictCount
);

  localparam int ENTRIES = 1 << BHT_INDEX_BITS;

  logic [1:0]            bht_q [ENTRIES];
  logic [1:0]            bht_d [ENTRIES];
  logic                  redirect_q, redirect_d;
  logic [BIT_COUNT-1:0]  redirect_pc_q, redirect_pc_d;
  logic [COUNT_BITS-1:0] mispredict_count_q, mispredict_count_d;

  logic [BHT_INDEX_BITS-1:0] fetch_idx;
  logic [BHT_INDEX_BITS-1:0] resolve_idx;
  logic                      actual_taken;
  logic                      funct3_legal;
  logic                      accept;
  logic                      mispredict;
  logic                      unused_fetch_bits;

  assign fetch_idx         = FetchPC[BHT_INDEX_BITS+1:2];
  assign resolve_idx       = ResolvePC[BHT_INDEX_BITS+1:2];
  assign unused_fetch_bits = ^{FetchPC[BIT_COUNT-1:BHT_INDEX_BITS+2], FetchPC[1:0]};

  // Prediction reads the pre-update table; a same-cycle update shows up next cycle.
  assign PredictTaken = bht_q[fetch_idx][1];

  always_comb begin
    actual_taken = 1'b0;
    funct3_legal = 1'b1;
    case (ResolveFunct3)
      3'b000:  actual_taken = Zero;
      3'b001:  actual_taken = ~Zero;
      3'b100:  actual_taken = Negative ^ oVerflow;
      3'b101:  actual_taken = ~(Negative ^ oVerflow);
      3'b110:  actual_taken = Carry;
      3'b111:  actual_taken = ~Carry;
      default: funct3_legal = 1'b0;
    endcase
  end

  // ResolveValid is a single-cycle valid with no ready: each resolve is either
  // accepted or dropped in the cycle it is presented. While a redirect is
  // outstanding, the branch in execute is wrong-path and is dropped.
  assign accept     = ResolveValid & funct3_legal & ~redirect_q;
  assign mispredict = accept & (actual_taken != ResolvePredictedTaken);

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      bht_d[i] = bht_q[i];
    end
    if (accept) begin
      if (actual_taken && (bht_q[resolve_idx] != 2'b11)) begin
        bht_d[resolve_idx] = bht_q[resolve_idx] + 2'b01;
      end else if (!actual_taken && (bht_q[resolve_idx] != 2'b00)) begin
        bht_d[resolve_idx] = bht_q[resolve_idx] - 2'b01;
      end
    end

    redirect_d    = mispredict;
    redirect_pc_d = redirect_pc_q;
    if (mispredict) begin
      redirect_pc_d = actual_taken ? ResolveTarget : ResolvePC + BIT_COUNT'(4);
    end

    mispredict_count_d = mispredict_count_q;
    if (mispredict && !(&mispredict_count_q)) begin
      mispredict_count_d = mispredict_count_q + COUNT_BITS'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        bht_q[i] <= 2'b01;
      end
      redirect_q         <= 1'b0;
      redirect_pc_q      <= '0;
      mispredict_count_q <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        bht_q[i] <= bht_d[i];
      end
      redirect_q         <= redirect_d;
      redirect_pc_q      <= redirect_pc_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign Redirect        = redirect_q;
  assign RedirectPC      = redirect_pc_q;
  assign MispredictCount = mispredict_count_q;

endmodule

// File: tb/tb_branch_flag_resolver.sv
// Bench for branch_flag_resolver: directed vector table followed by random
// operand-driven traffic, both checked against a comparison-based model.
module tb_branch_flag_resolver;

  logic        clk;
  logic        reset;
  logic [31:0] fetch_pc;
  logic        resolve_valid;
  logic [2:0]  resolve_funct3;
  logic [31:0] resolve_pc;
  logic [31:0] resolve_target;
  logic        resolve_pred;
  logic        zero, ovf, neg, carry;
  logic        predict_taken, redirect;
  logic [31:0] redirect_pc;
  logic [15:0] mis_count;
  logic        predict_taken2, redirect2;
  logic [31:0] redirect_pc2;
  logic [1:0]  mis_count2;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int          m_ctr [16];
  logic        m_red;
  logic [31:0] m_rpc;
  int          m_count;
  logic [31:0] exp_q[$];

  typedef struct {
    logic        rst;
    logic [31:0] fpc;
    logic        v;
    logic [2:0]  f3;
    logic [31:0] rpc;
    logic [31:0] tgt;
    logic        ptk;
    logic [31:0] a;
    logic [31:0] b;
    logic        chk;
    logic        e_pred;
    logic        e_red;
    logic [31:0] e_rpc;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  branch_flag_resolver dut (
    .clk(clk), .reset(reset), .FetchPC(fetch_pc), .PredictTaken(predict_taken),
    .ResolveValid(resolve_valid), .ResolveFunct3(resolve_funct3),
    .ResolvePC(resolve_pc), .ResolveTarget(resolve_target),
    .ResolvePredictedTaken(resolve_pred), .Zero(zero), .oVerflow(ovf),
    .Negative(neg), .Carry(carry), .Redirect(redirect), .RedirectPC(redirect_pc),
    .MispredictCount(mis_count)
  );

  branch_flag_resolver #(.COUNT_BITS(2)) dut2 (
    .clk(clk), .reset(reset), .FetchPC(fetch_pc), .PredictTaken(predict_taken2),
    .ResolveValid(resolve_valid), .ResolveFunct3(resolve_funct3),
    .ResolvePC(resolve_pc), .ResolveTarget(resolve_target),
    .ResolvePredictedTaken(resolve_pred), .Zero(zero), .oVerflow(ovf),
    .Negative(neg), .Carry(carry), .Redirect(redirect2), .RedirectPC(redirect_pc2),
    .MispredictCount(mis_count2)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_ctr[i] = 1;
    m_red   = 1'b0;
    m_rpc   = 32'h0;
    m_count = 0;
    exp_q.delete();
  endtask

  task automatic add(input logic rst, input logic [31:0] fpc, input logic v,
                     input logic [2:0] f3, input logic [31:0] rpc, input logic [31:0] tgt,
                     input logic ptk, input logic [31:0] a, input logic [31:0] b,
                     input logic chk, input logic e_pred, input logic e_red,
                     input logic [31:0] e_rpc, input logic [15:0] e_cnt);
    vec_t r;
    r.rst = rst; r.fpc = fpc; r.v = v; r.f3 = f3; r.rpc = rpc; r.tgt = tgt;
    r.ptk = ptk; r.a = a; r.b = b; r.chk = chk; r.e_pred = e_pred;
    r.e_red = e_red; r.e_rpc = e_rpc; r.e_cnt = e_cnt;
    vecs.push_back(r);
  endtask

  task automatic idle(input logic [31:0] fpc, input logic e_pred, input logic e_red,
                      input logic [31:0] e_rpc, input logic [15:0] e_cnt);
    add(1'b0, fpc, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1,
        e_pred, e_red, e_rpc, e_cnt);
  endtask

  // Driver: applies one cycle of stimulus, checks, then advances the model.
  task automatic step(input vec_t r);
    logic [32:0] diff;
    logic        legal, actual, accept;
    int          idx;
    @(negedge clk);
    reset          = r.rst;
    fetch_pc       = r.fpc;
    resolve_valid  = r.v;
    resolve_funct3 = r.f3;
    resolve_pc     = r.rpc;
    resolve_target = r.tgt;
    resolve_pred   = r.ptk;
    diff  = {1'b0, r.a} - {1'b0, r.b};
    zero  = (diff[31:0] == 32'h0);
    neg   = diff[31];
    carry = diff[32];
    ovf   = (r.a[31] != r.b[31]) && (diff[31] != r.a[31]);
    #1;

    check("predict", 32'(predict_taken), 32'(m_ctr[(r.fpc / 4) % 16] >= 2));
    check("redirect", 32'(redirect), 32'(m_red));
    check("redirect_pc", redirect_pc, m_rpc);
    check("count", 32'(mis_count), 32'(m_count));
    check("count_narrow", 32'(mis_count2), 32'((m_count > 3) ? 3 : m_count));
    if (m_red) begin
      if (exp_q.size() == 0) check("scoreboard_underflow", 32'(1), 32'(0));
      else check("redirect_target", redirect_pc, exp_q.pop_front());
    end
    if (r.chk) begin
      check("vec_predict", 32'(predict_taken), 32'(r.e_pred));
      check("vec_redirect", 32'(redirect), 32'(r.e_red));
      check("vec_redirect_pc", redirect_pc, r.e_rpc);
      check("vec_count", 32'(mis_count), 32'(r.e_cnt));
    end

    legal  = 1'b1;
    actual = 1'b0;
    case (r.f3)
      3'd0: actual = (r.a == r.b);
      3'd1: actual = (r.a != r.b);
      3'd4: actual = ($signed(r.a) <  $signed(r.b));
      3'd5: actual = ($signed(r.a) >= $signed(r.b));
      3'd6: actual = (r.a <  r.b);
      3'd7: actual = (r.a >= r.b);
      default: legal = 1'b0;
    endcase
    if (r.rst) begin
      model_reset();
    end else begin
      accept = r.v && legal && !m_red;
      idx    = (r.rpc / 4) % 16;
      if (accept) begin
        if (actual) m_ctr[idx] = (m_ctr[idx] == 3) ? 3 : m_ctr[idx] + 1;
        else        m_ctr[idx] = (m_ctr[idx] == 0) ? 0 : m_ctr[idx] - 1;
      end
      if (accept && (actual != r.ptk)) begin
        m_red   = 1'b1;
        m_rpc   = actual ? r.tgt : r.rpc + 32'd4;
        m_count = (m_count == 65535) ? 65535 : m_count + 1;
        exp_q.push_back(m_rpc);
      end else begin
        m_red = 1'b0;
      end
    end
    @(posedge clk);
  endtask

  task automatic hold_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    model_reset();
  endtask

  initial begin
    vec_t r;
    reset = 1'b1; fetch_pc = '0; resolve_valid = 1'b0; resolve_funct3 = '0;
    resolve_pc = '0; resolve_target = '0; resolve_pred = 1'b0;
    zero = 1'b0; ovf = 1'b0; neg = 1'b0; carry = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();

    // Reset defaults sweep
    for (int i = 0; i < 16; i++) idle(32'(i * 4), 1'b0, 1'b0, 32'h0, 16'd0);
    // BEQ mispredict, then prediction at the trained PC
    add(0, 32'h100, 1, 3'd0, 32'h100, 32'h80, 0, 32'd5, 32'd5, 1, 0, 0, 32'h0, 16'd0);
    idle(32'h100, 1'b1, 1'b1, 32'h80, 16'd1);
    // Signed vs unsigned for 0xFFFFFFFF - 1
    add(0, 32'h304, 1, 3'd6, 32'h304, 32'h400, 0, 32'hFFFFFFFF, 32'd1, 1, 0, 0, 32'h80, 16'd1);
    add(0, 32'h304, 1, 3'd4, 32'h308, 32'h500, 0, 32'hFFFFFFFF, 32'd1, 1, 0, 0, 32'h80, 16'd1);
    idle(32'h308, 1'b1, 1'b1, 32'h500, 16'd2);
    // Saturation at 11, then one not-taken still predicts taken
    for (int i = 0; i < 5; i++)
      add(0, 32'h40, 1, 3'd0, 32'h40, 32'h44, 1, 32'd5, 32'd5, 1, 1, 0, 32'h500, 16'd2);
    add(0, 32'h40, 1, 3'd0, 32'h40, 32'h44, 1, 32'd1, 32'd2, 1, 1, 0, 32'h500, 16'd2);
    idle(32'h40, 1'b1, 1'b1, 32'h44, 16'd3);
    // Fall-through wraps to 0
    add(0, 32'h3C, 1, 3'd1, 32'hFFFFFFFC, 32'h1000, 1, 32'd7, 32'd7, 1, 0, 0, 32'h44, 16'd3);
    idle(32'h3C, 1'b0, 1'b1, 32'h0, 16'd4);
    // Wrong-path drop right after a mispredict
    add(0, 32'h204, 1, 3'd0, 32'h200, 32'h600, 0, 32'd5, 32'd5, 1, 0, 0, 32'h0, 16'd4);
    add(0, 32'h204, 1, 3'd0, 32'h204, 32'h700, 0, 32'd5, 32'd5, 1, 0, 1, 32'h600, 16'd5);
    idle(32'h204, 1'b0, 1'b0, 32'h600, 16'd5);
    // Aliasing 0x10 / 0x50
    add(0, 32'h50, 1, 3'd0, 32'h10, 32'h20, 0, 32'd5, 32'd5, 1, 0, 0, 32'h600, 16'd5);
    idle(32'h50, 1'b1, 1'b1, 32'h20, 16'd6);
    // Illegal funct3 is dropped
    add(0, 32'h18, 1, 3'd2, 32'h18, 32'h30, 0, 32'd5, 32'd5, 1, 0, 0, 32'h20, 16'd6);
    idle(32'h18, 1'b0, 1'b0, 32'h20, 16'd6);
    // Same-index lookup and update: old value now, new value next cycle
    add(0, 32'h18, 1, 3'd7, 32'h18, 32'h30, 1, 32'd3, 32'd3, 1, 0, 0, 32'h20, 16'd6);
    idle(32'h18, 1'b1, 1'b0, 32'h20, 16'd6);
    // Reset in the cycle of a mispredicting resolve
    add(1, 32'h1C, 1, 3'd0, 32'h1C, 32'h900, 0, 32'd5, 32'd5, 1, 0, 0, 32'h20, 16'd6);
    idle(32'h1C, 1'b0, 1'b0, 32'h0, 16'd0);
    idle(32'h18, 1'b0, 1'b0, 32'h0, 16'd0);

    for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

    // Random traffic against the model
    hold_reset();
    for (int n = 0; n < 600; n++) begin
      r.rst = ($urandom_range(0, 99) == 0);
      r.fpc = {$urandom_range(0, 3) == 0 ? 32'($urandom) : 32'h0} ^ 32'($urandom_range(0, 31) * 4);
      r.v   = ($urandom_range(0, 9) < 7);
      r.f3  = 3'($urandom_range(0, 7));
      r.rpc = ($urandom_range(0, 19) == 0) ? 32'hFFFFFFFC : 32'($urandom_range(0, 31) * 4);
      r.tgt = 32'($urandom) & 32'hFFFFFFFC;
      r.ptk = 1'($urandom_range(0, 1));
      r.a   = ($urandom_range(0, 1) == 0) ? 32'($urandom) : 32'($urandom_range(0, 7));
      r.b   = ($urandom_range(0, 3) == 0) ? r.a : 32'($urandom);
      if ($urandom_range(0, 2) == 0) r.b = 32'($urandom_range(0, 7));
      r.chk = 1'b0; r.e_pred = 1'b0; r.e_red = 1'b0; r.e_rpc = 32'h0; r.e_cnt = 16'h0;
      step(r);
    end
    r.rst = 1'b0; r.v = 1'b0; r.fpc = 32'h0;
    step(r);
    step(r);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
